// File: rtl/stack_based_alu.sv
// Stack machine with a signed add/multiply unit working on the two top entries.
// All outputs are registered; one operation per clock, reset is synchronous active-low.
module stack_based_alu #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic        [2:0]        opcode,
  output logic signed [DATA_W-1:0] output_data,
  output logic                     overflow,
  output logic                     invalid
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  logic signed [DATA_W-1:0]   stack [DEPTH];
  logic        [SP_W-1:0]     sp;
  logic        [IDX_W-1:0]    top_idx;
  logic        [IDX_W-1:0]    second_idx;
  logic        [IDX_W-1:0]    wr_idx;
  logic signed [DATA_W-1:0]   top;
  logic signed [DATA_W-1:0]   second;
  logic signed [DATA_W-1:0]   sum;
  logic signed [2*DATA_W-1:0] prod;
  logic                       add_ovf;
  logic                       mul_ovf;
  logic                       full;
  logic                       empty;
  logic                       has_two;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign has_two = (sp >= SP_W'(2));

  // Indices are only meaningful when the matching stack condition holds.
  assign top_idx    = IDX_W'(sp - SP_W'(1));
  assign second_idx = IDX_W'(sp - SP_W'(2));
  assign wr_idx     = IDX_W'(sp);

  assign top    = stack[top_idx];
  assign second = stack[second_idx];

  assign sum     = top + second;
  assign add_ovf = (top[DATA_W-1] == second[DATA_W-1]) && (sum[DATA_W-1] != top[DATA_W-1]);

  // Full-width signed product; overflow when the upper half is not a sign extension.
  assign prod    = (2*DATA_W)'(top) * (2*DATA_W)'(second);
  assign mul_ovf = (prod != {{DATA_W{prod[DATA_W-1]}}, prod[DATA_W-1:0]});

  always_ff @(posedge clk) begin
    if (rst_n && opcode == OP_PUSH && !full) begin
      stack[wr_idx] <= input_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp          <= '0;
      output_data <= '0;
      overflow    <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      case (opcode)
        OP_ADD: begin
          if (has_two) begin
            output_data <= sum;
            overflow    <= add_ovf;
            invalid     <= 1'b0;
          end else begin
            overflow    <= 1'b0;
            invalid     <= 1'b1;
          end
        end
        OP_MUL: begin
          if (has_two) begin
            output_data <= prod[DATA_W-1:0];
            overflow    <= mul_ovf;
            invalid     <= 1'b0;
          end else begin
            overflow    <= 1'b0;
            invalid     <= 1'b1;
          end
        end
        OP_PUSH: begin
          overflow <= 1'b0;
          if (!full) begin
            sp      <= sp + SP_W'(1);
            invalid <= 1'b0;
          end else begin
            invalid <= 1'b1;
          end
        end
        OP_POP: begin
          overflow <= 1'b0;
          if (!empty) begin
            output_data <= top;
            sp          <= sp - SP_W'(1);
            invalid     <= 1'b0;
          end else begin
            invalid     <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_based_alu.sv
// Self-checking bench for stack_based_alu: per-scenario tasks push expected
// {output_data, overflow, invalid} into a scoreboard and compare one cycle later.
module tb_stack_based_alu;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;

  logic                     clk;
  logic                     rst_n;
  logic signed [DATA_W-1:0] input_data;
  logic        [2:0]        opcode;
  logic signed [DATA_W-1:0] output_data;
  logic                     overflow;
  logic                     invalid;

  typedef struct {
    logic                     rst;
    logic [2:0]               op;
    logic signed [DATA_W-1:0] din;
    logic signed [DATA_W-1:0] data;
    logic                     ovf;
    logic                     inv;
  } step_t;

  typedef struct {
    logic signed [DATA_W-1:0] data;
    logic                     ovf;
    logic                     inv;
  } exp_t;

  exp_t sb[$];
  int   total_checks;
  int   passed_checks;

  stack_based_alu #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_data  (input_data),
    .opcode      (opcode),
    .output_data (output_data),
    .overflow    (overflow),
    .invalid     (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t mk(input logic rst, input logic [2:0] op, input int din,
                               input int data, input logic ovf, input logic inv);
    step_t s;
    s.rst  = rst;
    s.op   = op;
    s.din  = din;
    s.data = data;
    s.ovf  = ovf;
    s.inv  = inv;
    return s;
  endfunction

  // Drives one step on the falling edge and records what it must produce.
  task automatic drive(input step_t s);
    exp_t e;
    @(negedge clk);
    rst_n      = !s.rst;
    opcode     = s.op;
    input_data = s.din;
    e.data = s.data;
    e.ovf  = s.ovf;
    e.inv  = s.inv;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t steps[$];
    exp_t  e;
    steps.push_back(mk(1, NOP, 0, 0, 0, 0));
    steps.push_back(mk(1, NOP, 0, 0, 0, 0));
    steps.push_back(mk(0, NOP, 0, 0, 0, 0));
    steps.push_back(mk(0, NOP, 0, 0, 0, 0));
    steps.push_back(mk(0, POP, 0, 0, 0, 1));
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sb.pop_front();
      total_checks++;
      if ({output_data, overflow, invalid} !== {e.data, e.ovf, e.inv})
        $display("[TB] FAIL reset[%0d] got data=%0d ovf=%b inv=%b want data=%0d ovf=%b inv=%b",
                 i, output_data, overflow, invalid, e.data, e.ovf, e.inv);
      else
        passed_checks++;
    end
  endtask

  task automatic test_add();
    step_t steps[$];
    exp_t  e;
    steps.push_back(mk(0, PUSH, 10, 0, 0, 0));
    steps.push_back(mk(0, ADD, 0, 0, 0, 1));
    steps.push_back(mk(0, PUSH, 22, 0, 0, 0));
    steps.push_back(mk(0, ADD, 0, 32, 0, 0));
    steps.push_back(mk(0, ADD, 0, 32, 0, 0));
    steps.push_back(mk(0, PUSH, 2000000000, 32, 0, 0));
    steps.push_back(mk(0, PUSH, 2000000000, 32, 0, 0));
    steps.push_back(mk(0, ADD, 0, -294967296, 1, 0));
    steps.push_back(mk(0, NOP, 0, -294967296, 1, 0));
    steps.push_back(mk(0, POP, 0, 2000000000, 0, 0));
    steps.push_back(mk(0, POP, 0, 2000000000, 0, 0));
    steps.push_back(mk(0, POP, 0, 22, 0, 0));
    steps.push_back(mk(0, POP, 0, 10, 0, 0));
    steps.push_back(mk(0, POP, 0, 10, 0, 1));
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sb.pop_front();
      total_checks++;
      if ({output_data, overflow, invalid} !== {e.data, e.ovf, e.inv})
        $display("[TB] FAIL add[%0d] got data=%0d ovf=%b inv=%b want data=%0d ovf=%b inv=%b",
                 i, output_data, overflow, invalid, e.data, e.ovf, e.inv);
      else
        passed_checks++;
    end
  endtask

  task automatic test_mul();
    step_t steps[$];
    exp_t  e;
    steps.push_back(mk(0, PUSH, -3, 10, 0, 0));
    steps.push_back(mk(0, MUL, 0, 10, 0, 1));
    steps.push_back(mk(0, PUSH, -5, 10, 0, 0));
    steps.push_back(mk(0, MUL, 0, 15, 0, 0));
    steps.push_back(mk(0, PUSH, 2000000, 15, 0, 0));
    steps.push_back(mk(0, PUSH, -1000000, 15, 0, 0));
    // -2e12 mod 2^32 = 1454759936
    steps.push_back(mk(0, MUL, 0, 1454759936, 1, 0));
    steps.push_back(mk(0, ADD, 0, 1000000, 0, 0));
    steps.push_back(mk(0, PUSH, 32'h8000_0000, 1000000, 0, 0));
    steps.push_back(mk(0, PUSH, -1, 1000000, 0, 0));
    steps.push_back(mk(0, ADD, 0, 32'h7FFF_FFFF, 1, 0));
    steps.push_back(mk(0, MUL, 0, 32'h8000_0000, 1, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sb.pop_front();
      total_checks++;
      if ({output_data, overflow, invalid} !== {e.data, e.ovf, e.inv})
        $display("[TB] FAIL mul[%0d] got data=%0d ovf=%b inv=%b want data=%0d ovf=%b inv=%b",
                 i, output_data, overflow, invalid, e.data, e.ovf, e.inv);
      else
        passed_checks++;
    end
  endtask

  task automatic test_full();
    step_t steps[$];
    exp_t  e;
    steps.push_back(mk(1, NOP, 0, 0, 0, 0));
    for (int k = 1; k <= DEPTH; k++)
      steps.push_back(mk(0, PUSH, 100 + k, 0, 0, 0));
    steps.push_back(mk(0, PUSH, 999, 0, 0, 1));
    steps.push_back(mk(0, POP, 0, 100 + DEPTH, 0, 0));
    steps.push_back(mk(0, POP, 0, 100 + DEPTH - 1, 0, 0));
    steps.push_back(mk(0, ADD, 0, (100 + DEPTH - 2) + (100 + DEPTH - 3), 0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sb.pop_front();
      total_checks++;
      if ({output_data, overflow, invalid} !== {e.data, e.ovf, e.inv})
        $display("[TB] FAIL full[%0d] got data=%0d ovf=%b inv=%b want data=%0d ovf=%b inv=%b",
                 i, output_data, overflow, invalid, e.data, e.ovf, e.inv);
      else
        passed_checks++;
    end
  endtask

  task automatic test_reset_mid();
    step_t steps[$];
    exp_t  e;
    steps.push_back(mk(0, PUSH, 7, 211, 0, 0));
    steps.push_back(mk(0, POP, 0, 7, 0, 0));
    steps.push_back(mk(1, PUSH, 55, 0, 0, 0));
    steps.push_back(mk(0, ADD, 0, 0, 0, 1));
    steps.push_back(mk(0, POP, 0, 0, 0, 1));
    steps.push_back(mk(0, PUSH, 4, 0, 0, 0));
    steps.push_back(mk(0, PUSH, 6, 0, 0, 0));
    steps.push_back(mk(0, MUL, 0, 24, 0, 0));
    steps.push_back(mk(0, POP, 0, 6, 0, 0));
    foreach (steps[i]) begin
      drive(steps[i]);
      e = sb.pop_front();
      total_checks++;
      if ({output_data, overflow, invalid} !== {e.data, e.ovf, e.inv})
        $display("[TB] FAIL reset_mid[%0d] got data=%0d ovf=%b inv=%b want data=%0d ovf=%b inv=%b",
                 i, output_data, overflow, invalid, e.data, e.ovf, e.inv);
      else
        passed_checks++;
    end
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst_n         = 1'b0;
    opcode        = NOP;
    input_data    = '0;
    test_reset();
    test_add();
    test_mul();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
